s_compute_acoustivdy_arb: RTL and testbench

- Shares one 8b×15b signed multiplier datapath among NUM_REQ requesters in the acoustic vdy compute stage.
- Uses round-robin arbitration with a valid/ready handshake on the request side.
- Pipelines the product over NUM_STAGE registered stages and carries a requester tag through the pipe.
- Returns each result only to the requester that issued the operands. Per-requester backpressure stalls the whole pipe.

---
 rtl/s_compute_acoustivdy_arb_pkg.sv | 25 ++
 rtl/s_compute_acoustivdy_arb_if.sv | 28 ++
 rtl/s_compute_acoustivdy_arb_mul.sv | 13 +
 rtl/s_compute_acoustivdy_rr_arb.sv | 33 +++
 rtl/s_compute_acoustivdy_arb.sv | 108 ++++++++++
 tb/tb_s_compute_acoustivdy_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/s_compute_acoustivdy_arb_pkg.sv
// Shared widths, saturation limits and pipe-stage record for the acoustic vdy
// multiplier arbiter.
package s_compute_acoustivdy_arb_pkg;

    localparam int A_WIDTH   = 8;
    localparam int B_WIDTH   = 15;
    localparam int P_WIDTH   = 15;
    localparam int FULL_W    = A_WIDTH + 1 + B_WIDTH;
    localparam int TAG_MAX_W = 3;

    function automatic int TAG_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam logic signed [FULL_W-1:0] P_MAX = FULL_W'((1 << (P_WIDTH - 1)) - 1);
    localparam logic signed [FULL_W-1:0] P_MIN = ~P_MAX;

    // Tag is sized for the largest supported requester count (8).
    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [P_WIDTH-1:0]   p;
    } stage_t;

endpackage

// File: rtl/s_compute_acoustivdy_arb_if.sv
// Request/response bundle between the requesters and the shared multiplier.
interface s_compute_acoustivdy_arb_if
    import s_compute_acoustivdy_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int TW = TAG_W(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*A_WIDTH-1:0] req_a;
    logic [NUM_REQ*B_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [NUM_REQ-1:0]         rsp_ready;
    logic [P_WIDTH-1:0]         rsp_p;
    logic [TW-1:0]              rsp_tag;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_p, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_p, rsp_tag
    );

endinterface

// File: rtl/s_compute_acoustivdy_arb_mul.sv
// DSP48-style multiply: unsigned A (zero-extended) times signed B, full width.
module s_compute_acoustivdy_arb_mul
    import s_compute_acoustivdy_arb_pkg::*;
(
    input  logic [A_WIDTH-1:0]       a_i,
    input  logic [B_WIDTH-1:0]       b_i,
    output logic signed [FULL_W-1:0] p_o
);

    assign p_o = $signed({{(FULL_W - A_WIDTH){1'b0}}, a_i})
               * $signed({{(FULL_W - B_WIDTH){b_i[B_WIDTH-1]}}, b_i});

endmodule

// File: rtl/s_compute_acoustivdy_rr_arb.sv
// Combinational round-robin grant: searches upward from ptr+1, wrapping.
module s_compute_acoustivdy_rr_arb
    import s_compute_acoustivdy_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TW      = TAG_W(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [TW-1:0]      ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [TW-1:0]      grant_idx_o,
    output logic               any_o
);

    int idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        idx         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (en_i && !any_o && req_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = TW'(idx);
            end
        end
    end

endmodule

// File: rtl/s_compute_acoustivdy_arb.sv
// Round-robin shared 8x15 signed multiplier with a tagged NUM_STAGE pipe.
// Define S_COMPUTE_ACOUSTIVDY_ARB_SAT_EN to saturate products instead of truncating.
module s_compute_acoustivdy_arb
    import s_compute_acoustivdy_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_STAGE = 2
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    s_compute_acoustivdy_arb_if.slave bus
);

    localparam int TW = TAG_W(NUM_REQ);

    stage_t               stage_q [NUM_STAGE];
    stage_t               stage_d [NUM_STAGE];
    logic [TW-1:0]        ptr_q, ptr_d;

    stage_t               last;
    logic [TW-1:0]        last_tag;
    logic                 stall;
    logic [NUM_REQ-1:0]   grant;
    logic [TW-1:0]        grant_idx;
    logic                 hs;
    logic [A_WIDTH-1:0]   a_sel;
    logic [B_WIDTH-1:0]   b_sel;
    logic signed [FULL_W-1:0] full_p;
    logic [P_WIDTH-1:0]   p_res;
    logic                 unused_tag_bits;

    assign last            = stage_q[NUM_STAGE-1];
    assign last_tag        = last.tag[TW-1:0];
    assign unused_tag_bits = ^last.tag;
    // A bubble at the output never holds the pipe.
    assign stall           = last.valid & ~bus.rsp_ready[last_tag];

    s_compute_acoustivdy_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .TW      (TW)
    ) u_arb (
        .req_i       (bus.req_valid),
        .ptr_i       (ptr_q),
        .en_i        (ap_rst_n & ~stall),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (hs)
    );

    assign bus.req_ready = grant;
    assign a_sel = bus.req_a[int'(grant_idx)*A_WIDTH +: A_WIDTH];
    assign b_sel = bus.req_b[int'(grant_idx)*B_WIDTH +: B_WIDTH];

    s_compute_acoustivdy_arb_mul u_mul (
        .a_i (a_sel),
        .b_i (b_sel),
        .p_o (full_p)
    );

    always_comb begin
`ifdef S_COMPUTE_ACOUSTIVDY_ARB_SAT_EN
        if (full_p > P_MAX) begin
            p_res = P_MAX[P_WIDTH-1:0];
        end else if (full_p < P_MIN) begin
            p_res = P_MIN[P_WIDTH-1:0];
        end else begin
            p_res = full_p[P_WIDTH-1:0];
        end
`else
        p_res = full_p[P_WIDTH-1:0];
`endif
    end

    // Tag/product only load with a valid entry so rsp_p holds across bubbles.
    always_comb begin
        ptr_d   = hs ? grant_idx : ptr_q;
        stage_d = stage_q;
        if (!stall) begin
            stage_d[0].valid = hs;
            if (hs) begin
                stage_d[0].tag = TAG_MAX_W'(grant_idx);
                stage_d[0].p   = p_res;
            end
            for (int k = 1; k < NUM_STAGE; k++) begin
                stage_d[k].valid = stage_q[k-1].valid;
                if (stage_q[k-1].valid) begin
                    stage_d[k].tag = stage_q[k-1].tag;
                    stage_d[k].p   = stage_q[k-1].p;
                end
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_q   <= TW'(NUM_REQ - 1);
            stage_q <= '{default: '0};
        end else begin
            ptr_q   <= ptr_d;
            stage_q <= stage_d;
        end
    end

    assign bus.rsp_valid = last.valid ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << last_tag) : '0;
    assign bus.rsp_p     = last.p;
    assign bus.rsp_tag   = last_tag;

endmodule

// File: tb/tb_s_compute_acoustivdy_arb.sv
// Self-checking bench for the shared multiplier arbiter: directed scenarios plus
// a randomized run against an accept-queue/latency reference model.
module tb_s_compute_acoustivdy_arb;
    import s_compute_acoustivdy_arb_pkg::*;

    localparam int NR = 4;
    localparam int NS = 2;

    typedef struct {
        int         tag;
        logic [14:0] p;
        int         age;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    s_compute_acoustivdy_arb_if #(.NUM_REQ(NR)) bus ();

    s_compute_acoustivdy_arb #(.NUM_REQ(NR), .NUM_STAGE(NS)) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus)
    );

    function automatic logic [14:0] ref_p(input int a, input int b);
        int full;
        full = a * b;
`ifdef S_COMPUTE_ACOUSTIVDY_ARB_SAT_EN
        if (full > 16383)  return 15'h3FFF;
        if (full < -16384) return 15'h4000;
`endif
        return full[14:0];
    endfunction

    function automatic int rnd_b();
        return int'($urandom_range(0, 32767)) - 16384;
    endfunction

    task automatic set_req(input int i, input int a, input int b);
        bus.req_valid[i]          = 1'b1;
        bus.req_a[i*8 +: 8]       = 8'(a);
        bus.req_b[i*15 +: 15]     = 15'(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.rsp_ready = '1;
        for (int i = 0; i < NR; i++) set_req(i, i + 1, i + 1);
        tick();
        tick();
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=%b", bus.req_ready, 4'b0000); end
        n_tests++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=%b", bus.rsp_valid, 4'b0000); end
        n_tests++; if (bus.rsp_p !== 15'd0) begin n_fail++; $display("FAIL reset_rsp_p got=%0h exp=0", bus.rsp_p); end
        n_tests++; if (bus.rsp_tag !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_tag got=%0d exp=0", bus.rsp_tag); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got=%b exp=%b", bus.req_ready, 4'b0001); end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_single_op();
        do_reset();
        set_req(0, 3, -5);
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        n_tests++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early got=%b exp=0000", bus.rsp_valid); end
        tick();
        @(negedge clk);
        n_tests++; if (bus.rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid got=%b exp=0001", bus.rsp_valid); end
        n_tests++; if (bus.rsp_p !== 15'h7FF1) begin n_fail++; $display("FAIL single_p got=%0h exp=7ff1", bus.rsp_p); end
        n_tests++; if (bus.rsp_tag !== 2'd0) begin n_fail++; $display("FAIL single_tag got=%0d exp=0", bus.rsp_tag); end
        tick();
        @(negedge clk);
        n_tests++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_after got=%b exp=0000", bus.rsp_valid); end
        n_tests++; if (bus.rsp_p !== 15'h7FF1) begin n_fail++; $display("FAIL single_hold got=%0h exp=7ff1", bus.rsp_p); end
    endtask

    task automatic test_fairness();
        int va[NR];
        int vb[NR];
        int et[10];
        logic [14:0] ep[10];
        int g;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            va[i] = int'($urandom_range(0, 255));
            vb[i] = rnd_b();
            set_req(i, va[i], vb[i]);
        end
        for (int c = 0; c < 10; c++) begin
            g = c % NR;
            @(negedge clk);
            if (c < 8) begin
                n_tests++; if (bus.req_ready !== 4'(1 << g)) begin n_fail++; $display("FAIL fair_grant c=%0d got=%b exp=%b", c, bus.req_ready, 4'(1 << g)); end
                et[c] = g;
                ep[c] = ref_p(va[g], vb[g]);
            end
            if (c >= 2) begin
                n_tests++; if (bus.rsp_valid !== 4'(1 << et[c-2])) begin n_fail++; $display("FAIL fair_valid c=%0d got=%b exp=%b", c, bus.rsp_valid, 4'(1 << et[c-2])); end
                n_tests++; if (bus.rsp_p !== ep[c-2]) begin n_fail++; $display("FAIL fair_p c=%0d got=%0h exp=%0h", c, bus.rsp_p, ep[c-2]); end
                n_tests++; if (bus.rsp_tag !== 2'(et[c-2])) begin n_fail++; $display("FAIL fair_tag c=%0d got=%0d exp=%0d", c, bus.rsp_tag, et[c-2]); end
            end
            tick();
            if (c < 8) begin
                va[g] = int'($urandom_range(0, 255));
                vb[g] = rnd_b();
                set_req(g, va[g], vb[g]);
            end
            if (c == 7) bus.req_valid = '0;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(1, 10, 7);
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant1 got=%b exp=0010", bus.req_ready); end
        tick();
        bus.req_valid[1] = 1'b0;
        set_req(0, 2, 3);
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_grant0 got=%b exp=0001", bus.req_ready); end
        tick();
        bus.req_valid[0] = 1'b0;
        set_req(2, 5, -9);
        bus.rsp_ready[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++; if (bus.rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_stall_valid c=%0d got=%b exp=0010", c, bus.rsp_valid); end
            n_tests++; if (bus.rsp_p !== 15'd70) begin n_fail++; $display("FAIL bp_stall_p c=%0d got=%0d exp=70", c, bus.rsp_p); end
            n_tests++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready c=%0d got=%b exp=0000", c, bus.req_ready); end
            tick();
        end
        bus.rsp_ready[1] = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_resume_valid got=%b exp=0010", bus.rsp_valid); end
        n_tests++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_resume_ready got=%b exp=0100", bus.req_ready); end
        tick();
        bus.req_valid[2] = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL bp_next_valid got=%b exp=0001", bus.rsp_valid); end
        n_tests++; if (bus.rsp_p !== 15'd6) begin n_fail++; $display("FAIL bp_next_p got=%0d exp=6", bus.rsp_p); end
        tick();
        @(negedge clk);
        n_tests++; if (bus.rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL bp_third_valid got=%b exp=0100", bus.rsp_valid); end
        n_tests++; if (bus.rsp_p !== ref_p(5, -9)) begin n_fail++; $display("FAIL bp_third_p got=%0h exp=%0h", bus.rsp_p, ref_p(5, -9)); end
        tick();
        @(negedge clk);
        n_tests++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_dup got=%b exp=0000", bus.rsp_valid); end
    endtask

    task automatic test_width_edge();
        logic [14:0] exp_hi;
`ifdef S_COMPUTE_ACOUSTIVDY_ARB_SAT_EN
        exp_hi = 15'd16383;
`else
        exp_hi = 15'd16129;
`endif
        do_reset();
        set_req(3, 255, 16383);
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL edge_grant3 got=%b exp=1000", bus.req_ready); end
        tick();
        bus.req_valid[3] = 1'b0;
        set_req(0, 255, -16384);
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL edge_grant0 got=%b exp=0001", bus.req_ready); end
        tick();
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.rsp_valid !== 4'b1000) begin n_fail++; $display("FAIL edge_valid_hi got=%b exp=1000", bus.rsp_valid); end
        n_tests++; if (bus.rsp_p !== exp_hi) begin n_fail++; $display("FAIL edge_p_hi got=%0d exp=%0d", bus.rsp_p, exp_hi); end
        n_tests++; if (bus.rsp_tag !== 2'd3) begin n_fail++; $display("FAIL edge_tag_hi got=%0d exp=3", bus.rsp_tag); end
        tick();
        @(negedge clk);
        n_tests++; if (bus.rsp_p !== 15'h4000) begin n_fail++; $display("FAIL edge_p_lo got=%0h exp=4000", bus.rsp_p); end
        tick();
    endtask

    task automatic test_reset_midop();
        do_reset();
        set_req(1, 4, 4);
        tick();
        bus.req_valid[1] = 1'b0;
        set_req(2, 6, 6);
        tick();
        bus.req_valid[2] = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL rmid_before got=%b exp=0010", bus.rsp_valid); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rmid_async got=%b exp=0000", bus.rsp_valid); end
        n_tests++; if (bus.rsp_p !== 15'd0) begin n_fail++; $display("FAIL rmid_p got=%0d exp=0", bus.rsp_p); end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rmid_ghost c=%0d got=%b exp=0000", c, bus.rsp_valid); end
            tick();
        end
        for (int i = 0; i < NR; i++) set_req(i, 1, 1);
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_grant got=%b exp=0001", bus.req_ready); end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_bubble();
        logic [14:0] ep[8];
        int a;
        int b;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c < 8 && (c % 2) == 0) begin
                a = int'($urandom_range(0, 255));
                b = rnd_b();
                set_req(2, a, b);
                ep[c] = ref_p(a, b);
            end else begin
                bus.req_valid[2] = 1'b0;
            end
            @(negedge clk);
            n_tests++; if (bus.req_ready !== ((c < 8 && (c % 2) == 0) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL bubble_ready c=%0d got=%b", c, bus.req_ready); end
            if (c >= 2 && (c % 2) == 0) begin
                n_tests++; if (bus.rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL bubble_valid c=%0d got=%b exp=0100", c, bus.rsp_valid); end
                n_tests++; if (bus.rsp_p !== ep[c-2]) begin n_fail++; $display("FAIL bubble_p c=%0d got=%0h exp=%0h", c, bus.rsp_p, ep[c-2]); end
            end else begin
                n_tests++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL bubble_gap c=%0d got=%b exp=0000", c, bus.rsp_valid); end
            end
            tick();
        end
        for (int i = 0; i < NR; i++) set_req(i, 1, 1);
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL bubble_ptr got=%b exp=1000", bus.req_ready); end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        ent_t        q[$];
        logic        pv[NR];
        int          pa[NR];
        int          pb[NR];
        int          ptr_m;
        int          g;
        int          idx;
        logic        out_v;
        logic        stall;
        logic        drain;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_valid;
        logic [14:0] exp_p;
        logic [14:0] held_p;
        do_reset();
        ptr_m  = NR - 1;
        held_p = '0;
        for (int i = 0; i < NR; i++) pv[i] = 1'b0;
        for (int c = 0; c < 420; c++) begin
            drain = (c >= 400);
            for (int i = 0; i < NR; i++) begin
                if (!pv[i] && !drain && $urandom_range(0, 2) == 0) begin
                    pv[i] = 1'b1;
                    pa[i] = int'($urandom_range(0, 255));
                    pb[i] = rnd_b();
                    set_req(i, pa[i], pb[i]);
                end
                bus.req_valid[i] = pv[i];
            end
            bus.rsp_ready = drain ? 4'hF : 4'($urandom_range(0, 15));
            out_v = (q.size() > 0) && (q[0].age == NS);
            stall = out_v && !bus.rsp_ready[q[0].tag];
            g = -1;
            if (!stall) begin
                for (int k = 1; k <= NR; k++) begin
                    idx = (ptr_m + k) % NR;
                    if (g < 0 && pv[idx]) g = idx;
                end
            end
            exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
            exp_valid = out_v ? 4'(1 << q[0].tag) : 4'b0000;
            exp_p     = out_v ? q[0].p : held_p;
            @(negedge clk);
            n_tests++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_ready); end
            n_tests++; if (bus.rsp_valid !== exp_valid) begin n_fail++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, bus.rsp_valid, exp_valid); end
            n_tests++; if (bus.rsp_p !== exp_p) begin n_fail++; $display("FAIL rand_p c=%0d got=%0h exp=%0h", c, bus.rsp_p, exp_p); end
            if (out_v) begin
                n_tests++; if (bus.rsp_tag !== 2'(q[0].tag)) begin n_fail++; $display("FAIL rand_tag c=%0d got=%0d exp=%0d", c, bus.rsp_tag, q[0].tag); end
            end
            held_p = exp_p;
            if (!stall) begin
                if (out_v) void'(q.pop_front());
                for (int j = 0; j < q.size(); j++) q[j].age = q[j].age + 1;
                if (g >= 0) begin
                    q.push_back('{g, ref_p(pa[g], pb[g]), 1});
                    pv[g]  = 1'b0;
                    ptr_m  = g;
                end
            end
            tick();
        end
        n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_drain got=%0d exp=0 outstanding", q.size()); end
        bus.req_valid = '0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '1;
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_width_edge();
        test_reset_midop();
        test_bubble();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
